// File: rtl/spart_driver_if.sv
// Bus between spart_driver and the SPART: control lines driven by the driver,
// rda/tbr sideband status returned from the SPART.
interface spart_driver_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
    modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);
endinterface

// File: rtl/spart_driver.sv
// SPART bus master: programs the baud divisor after reset, then echoes every
// received byte back to the transmitter through a small FIFO.
module spart_driver #(
    parameter logic [15:0] DIV0       = 16'd1301,
    parameter logic [15:0] DIV1       = 16'd650,
    parameter logic [15:0] DIV2       = 16'd324,
    parameter logic [15:0] DIV3       = 16'd161,
    parameter int          FIFO_DEPTH = 4,
    parameter int          TBR_WAIT   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    br_cfg,
    spart_driver_if.master                bus,
    inout  wire  [7:0]                    databus,
    output logic                          cfg_done,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int GRD_W = $clog2(TBR_WAIT + 1);

    localparam logic [1:0] CFG_LO = 2'd0;
    localparam logic [1:0] CFG_HI = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DLO  = 2'b10;
    localparam logic [1:0] ADDR_DHI  = 2'b11;

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [GRD_W-1:0] GRD_LOAD = GRD_W'(TBR_WAIT);

    logic [1:0]       state_r, state_s;
    logic             iocs_r, iocs_s;
    logic             iorw_r, iorw_s;
    logic [1:0]       ioaddr_r, ioaddr_s;
    logic [7:0]       wdata_r, wdata_s;
    logic [1:0]       br_cfg_q_r, br_cfg_q_s;
    logic             cfg_done_r, cfg_done_s;
    logic [1:0]       br_sync_r;
    logic             overrun_r;
    logic             pend_rx_r;
    logic             rd_busy_r;
    logic             rd_issue_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic [GRD_W-1:0] guard_r;
    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;

    function automatic logic [7:0] div_byte(input logic [1:0] cfg, input logic hi);
        logic [15:0] d;
        case (cfg)
            2'b00:   d = DIV0;
            2'b01:   d = DIV1;
            2'b10:   d = DIV2;
            2'b11:   d = DIV3;
            default: d = DIV3;
        endcase
        return hi ? d[15:8] : d[7:0];
    endfunction

    // Next bus operation; it appears on the registered outputs for the following cycle.
    always_comb begin
        state_s    = state_r;
        iocs_s     = 1'b0;
        iorw_s     = 1'b1;
        ioaddr_s   = ADDR_STAT;
        wdata_s    = 8'h00;
        br_cfg_q_s = br_cfg_q_r;
        cfg_done_s = cfg_done_r;
        rd_issue_s = 1'b0;
        pop_s      = 1'b0;
        case (state_r)
            CFG_LO: begin
                iocs_s     = 1'b1;
                iorw_s     = 1'b0;
                ioaddr_s   = ADDR_DLO;
                wdata_s    = div_byte(br_cfg, 1'b0);
                br_cfg_q_s = br_cfg;
                state_s    = CFG_HI;
            end
            CFG_HI: begin
                iocs_s     = 1'b1;
                iorw_s     = 1'b0;
                ioaddr_s   = ADDR_DHI;
                wdata_s    = div_byte(br_cfg_q_r, 1'b1);
                cfg_done_s = 1'b1;
                state_s    = RUN;
            end
            RUN: begin
                if (pend_rx_r) begin
                    iocs_s     = 1'b1;
                    ioaddr_s   = ADDR_BUF;
                    rd_issue_s = 1'b1;
                end else if (br_sync_r != br_cfg_q_r) begin
                    state_s = CFG_LO;
                end else if ((level_r != {LVL_W{1'b0}}) && bus.tbr && (guard_r == {GRD_W{1'b0}})) begin
                    iocs_s   = 1'b1;
                    iorw_s   = 1'b0;
                    ioaddr_s = ADDR_BUF;
                    wdata_s  = mem_r[rd_ptr_r];
                    pop_s    = 1'b1;
                end else begin
                    state_s = RUN;
                end
            end
            default: state_s = CFG_LO;
        endcase
    end

    // A read completes at the edge ending its cycle; a pop in the same edge frees a slot.
    assign push_s = rd_busy_r && ((level_r != LVL_FULL) || pop_s);
    assign drop_s = rd_busy_r && (level_r == LVL_FULL) && !pop_s;

    // Sequencer, bus output registers, FIFO and guard counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= CFG_LO;
            iocs_r     <= 1'b0;
            iorw_r     <= 1'b1;
            ioaddr_r   <= ADDR_STAT;
            wdata_r    <= 8'h00;
            br_cfg_q_r <= 2'b00;
            br_sync_r  <= 2'b00;
            cfg_done_r <= 1'b0;
            overrun_r  <= 1'b0;
            pend_rx_r  <= 1'b0;
            rd_busy_r  <= 1'b0;
            guard_r    <= {GRD_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            level_r    <= {LVL_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            state_r    <= state_s;
            iocs_r     <= iocs_s;
            iorw_r     <= iorw_s;
            ioaddr_r   <= ioaddr_s;
            wdata_r    <= wdata_s;
            br_cfg_q_r <= br_cfg_q_s;
            br_sync_r  <= br_cfg;
            cfg_done_r <= cfg_done_s;
            rd_busy_r  <= rd_issue_s;
            // A new rda pulse must survive the clear from the read being issued now.
            if (bus.rda) begin
                pend_rx_r <= 1'b1;
            end else if (rd_issue_s) begin
                pend_rx_r <= 1'b0;
            end else begin
                pend_rx_r <= pend_rx_r;
            end
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
            if (push_s) begin
                mem_r[wr_ptr_r] <= databus;
                wr_ptr_r        <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
                guard_r  <= GRD_LOAD;
            end else if (guard_r != {GRD_W{1'b0}}) begin
                guard_r <= guard_r - {{(GRD_W-1){1'b0}}, 1'b1};
            end else begin
                guard_r <= guard_r;
            end
            if (push_s && !pop_s) begin
                level_r <= level_r + {{(LVL_W-1){1'b0}}, 1'b1};
            end else if (pop_s && !push_s) begin
                level_r <= level_r - {{(LVL_W-1){1'b0}}, 1'b1};
            end else begin
                level_r <= level_r;
            end
        end
    end

    assign bus.iocs   = iocs_r;
    assign bus.iorw   = iorw_r;
    assign bus.ioaddr = ioaddr_r;
    assign databus    = (iocs_r && !iorw_r) ? wdata_r : 8'bzzzz_zzzz;
    assign cfg_done   = cfg_done_r;
    assign overrun    = overrun_r;
    assign fifo_level = level_r;
endmodule

// File: tb/tb_spart_driver.sv
// Self-checking bench for spart_driver: a behavioural SPART supplies RX bytes,
// and a scoreboard queue holds the bytes expected back on the transmit side.
module tb_spart_driver;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       cfg_done;
    logic       overrun;
    logic [2:0] fifo_level;
    logic [7:0] rx_byte;
    logic       exp_ovr;
    tri1  [7:0] databus;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         last_wr_cyc = -100;
    int         rd_at;
    int         lo_at;
    logic [7:0] lo_v;
    logic [7:0] hi_v;
    logic [7:0] exp_q [$];

    spart_driver_if bus_if ();

    spart_driver dut (
        .clk        (clk),
        .rst        (rst),
        .br_cfg     (br_cfg),
        .bus        (bus_if.master),
        .databus    (databus),
        .cfg_done   (cfg_done),
        .overrun    (overrun),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SPART read mux: drives the RX buffer only during a buffer read.
    assign databus = (bus_if.iocs && bus_if.iorw && bus_if.ioaddr == 2'b00) ? rx_byte : 8'bzzzz_zzzz;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transmit-side scoreboard: every TX buffer write must match the oldest expected byte.
    always @(negedge clk) begin
        if (bus_if.iocs && !bus_if.iorw && bus_if.ioaddr == 2'b00) begin
            check_eq("tx_expected", 16'(exp_q.size() != 0), 16'd1);
            if (exp_q.size() != 0) begin
                check_eq("tx_byte", 16'(databus), 16'(exp_q.pop_front()));
            end
            check_eq("tx_gap", 16'((cyc - last_wr_cyc) >= 5), 16'd1);
            last_wr_cyc <= cyc;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte    = b;
        bus_if.rda = 1'b1;
        if (exp_q.size() < 4) exp_q.push_back(b);
        else exp_ovr = 1'b1;
        @(negedge clk);
        bus_if.rda = 1'b0;
    endtask

    task automatic wait_op(input logic rw, input logic [1:0] addr, input int budget, input string tag);
        int n = 0;
        while (!(bus_if.iocs && bus_if.iorw == rw && bus_if.ioaddr == addr) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, {12'h000, bus_if.iocs, bus_if.iorw, bus_if.ioaddr}, {12'h000, 1'b1, rw, addr});
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 16'(exp_q.size()), 16'd0);
    endtask

    task automatic check_cfg(input logic [7:0] lo, input logic [7:0] hi, input logic done0, input string tag);
        @(negedge clk);
        check_eq({tag, "_lo_ctl"}, {12'h000, bus_if.iocs, bus_if.iorw, bus_if.ioaddr}, 16'h000A);
        check_eq({tag, "_lo_data"}, 16'(databus), 16'(lo));
        check_eq({tag, "_done_lo"}, 16'(cfg_done), 16'(done0));
        @(negedge clk);
        check_eq({tag, "_hi_ctl"}, {12'h000, bus_if.iocs, bus_if.iorw, bus_if.ioaddr}, 16'h000B);
        check_eq({tag, "_hi_data"}, 16'(databus), 16'(hi));
        @(negedge clk);
        check_eq({tag, "_idle_cs"}, 16'(bus_if.iocs), 16'd0);
        check_eq({tag, "_done"}, 16'(cfg_done), 16'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ctl"}, {12'h000, bus_if.iocs, bus_if.iorw, bus_if.ioaddr}, 16'h0005);
        check_eq({tag, "_bus_z"}, 16'(databus), 16'h00FF);
        check_eq({tag, "_done"}, 16'(cfg_done), 16'd0);
        check_eq({tag, "_ovr"}, 16'(overrun), 16'd0);
        check_eq({tag, "_lvl"}, 16'(fifo_level), 16'd0);
    endtask

    initial begin
        rst        = 1'b0;
        br_cfg     = 2'b01;
        bus_if.rda = 1'b0;
        bus_if.tbr = 1'b0;
        rx_byte    = 8'h00;
        exp_ovr    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b1;
        check_cfg(8'h8A, 8'h02, 1'b0, "cfg01");

        // single byte echo
        bus_if.tbr = 1'b1;
        send_byte(8'h41);
        wait_op(1'b1, 2'b00, 6, "echo_rd");
        @(negedge clk);
        check_eq("echo_lvl1", 16'(fifo_level), 16'd1);
        wait_drain(20, "echo_drain");
        check_eq("echo_lvl0", 16'(fifo_level), 16'd0);

        // overflow with transmitter blocked
        bus_if.tbr = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i));
            repeat (8) @(negedge clk);
            if (i == 4) check_eq("ovf_ovr_before", 16'(overrun), 16'd0);
        end
        check_eq("ovf_lvl_full", 16'(fifo_level), 16'd4);
        check_eq("ovf_ovr", 16'(overrun), 16'(exp_ovr));
        bus_if.tbr = 1'b1;
        wait_drain(60, "ovf_drain");
        repeat (10) @(negedge clk);
        check_eq("ovf_lvl_empty", 16'(fifo_level), 16'd0);
        check_eq("ovf_ovr_sticky", 16'(overrun), 16'd1);

        // baud change with a simultaneous rda: the read must come first
        bus_if.tbr = 1'b0;
        @(negedge clk);
        br_cfg     = 2'b11;
        rx_byte    = 8'h55;
        bus_if.rda = 1'b1;
        exp_q.push_back(8'h55);
        @(negedge clk);
        bus_if.rda = 1'b0;
        rd_at = -1;
        lo_at = -1;
        lo_v  = 8'h00;
        hi_v  = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.iocs && bus_if.iorw && bus_if.ioaddr == 2'b00 && rd_at < 0) rd_at = i;
            if (bus_if.iocs && !bus_if.iorw && bus_if.ioaddr == 2'b10 && lo_at < 0) begin
                lo_at = i;
                lo_v  = databus;
            end
            if (bus_if.iocs && !bus_if.iorw && bus_if.ioaddr == 2'b11) hi_v = databus;
        end
        check_eq("rcfg_rd_seen", 16'(rd_at >= 0), 16'd1);
        check_eq("rcfg_lo_seen", 16'(lo_at >= 0), 16'd1);
        check_eq("rcfg_rd_first", 16'(rd_at < lo_at), 16'd1);
        check_eq("rcfg_lo_data", 16'(lo_v), 16'h00A1);
        check_eq("rcfg_hi_data", 16'(hi_v), 16'h0000);
        bus_if.tbr = 1'b1;
        wait_drain(20, "rcfg_drain");

        // rda during configuration is held until the first RUN cycle
        bus_if.tbr = 1'b0;
        @(negedge clk);
        br_cfg = 2'b01;
        wait_op(1'b0, 2'b10, 10, "cfgrx_lo");
        check_eq("cfgrx_lo_data", 16'(databus), 16'h008A);
        rx_byte    = 8'h66;
        bus_if.rda = 1'b1;
        exp_q.push_back(8'h66);
        @(negedge clk);
        bus_if.rda = 1'b0;
        check_eq("cfgrx_hi_data", 16'(databus), 16'h0002);
        @(negedge clk);
        check_eq("cfgrx_rd_first", {12'h000, bus_if.iocs, bus_if.iorw, bus_if.ioaddr}, 16'h000C);
        bus_if.tbr = 1'b1;
        wait_drain(20, "cfgrx_drain");

        // asynchronous reset in the middle of a TX write
        bus_if.tbr = 1'b0;
        send_byte(8'h77);
        repeat (4) @(negedge clk);
        send_byte(8'h78);
        repeat (6) @(negedge clk);
        check_eq("rstw_lvl2", 16'(fifo_level), 16'd2);
        bus_if.tbr = 1'b1;
        wait_op(1'b0, 2'b00, 20, "rstw_wr");
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("rstw");
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        check_cfg(8'h8A, 8'h02, 1'b0, "rstw_cfg");
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
